// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Sequences one SRAM row access at a time: bitline precharge, then wordline
//   assertion (with write drive on writes), then sense (reads only), then a
//   one-cycle response pulse. Sits directly upstream of the write driver,
//   the wordline array and the sense amps.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high
//   req_valid    in   request present
//   req_ready    out  request accepted when high (IDLE only, low while rst)
//   req_we       in   1 = write, 0 = read
//   req_addr     in   row address (ADDR_W)
//   req_wdata    in   write data (COLS)
//   rsp_valid    out  one-cycle pulse: access complete
//   rsp_rdata    out  read data, valid with rsp_valid on reads; held otherwise
//   precharge_en out  bitline precharge enable
//   wl_sel       out  one-hot wordline enables (ROWS)
//   wd_en        out  write-driver enable
//   data_in      out  write data towards the write driver
//   sa_en        out  sense-amp enable
//   sa_out       in   sense-amp outputs (COLS)
module sram_access_ctrl #(
  parameter int COLS    = 8,
  parameter int ROWS    = 16,
  parameter int ADDR_W  = $clog2(ROWS),
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2,
  parameter int SA_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [COLS-1:0]   rsp_rdata,
  output logic              precharge_en,
  output logic [ROWS-1:0]   wl_sel,
  output logic              wd_en,
  output logic [COLS-1:0]   data_in,
  output logic              sa_en,
  input  logic [COLS-1:0]   sa_out
);

  generate
    if (PRE_CYC < 1) begin : g_bad_pre
      $error("sram_access_ctrl: PRE_CYC must be >= 1");
    end
    if (WL_CYC < 1) begin : g_bad_wl
      $error("sram_access_ctrl: WL_CYC must be >= 1");
    end
    if (SA_CYC < 1) begin : g_bad_sa
      $error("sram_access_ctrl: SA_CYC must be >= 1");
    end
  endgenerate

  localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? ((PRE_CYC > SA_CYC) ? PRE_CYC : SA_CYC)
                                              : ((WL_CYC > SA_CYC) ? WL_CYC : SA_CYC);
  // The counter only ever holds (cycles - 1), so clog2(MAX_CYC) bits suffice.
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  PRE_LD    = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0]  WL_LD     = CNT_W'(WL_CYC - 1);
  localparam logic [CNT_W-1:0]  SA_LD     = CNT_W'(SA_CYC - 1);
  // One extra bit so ROWS itself is representable when ROWS is a power of two.
  localparam logic [ADDR_W:0]   ROW_LIMIT = (ADDR_W + 1)'(ROWS);
  localparam logic [ROWS-1:0]   WL_ONE    = ROWS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_SENSE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLS-1:0]   data_in_q, data_in_d;
  logic [COLS-1:0]   rdata_q, rdata_d;
  logic              in_range;

  assign in_range = ({1'b0, addr_q} < ROW_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_in_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_in_d = data_in_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_PRE;
          cnt_d   = PRE_LD;
          we_d    = req_we;
          addr_d  = req_addr;
          // data_in tracks the last accepted write; reads leave it alone.
          if (req_we) data_in_d = req_wdata;
        end
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          state_d = S_ACT;
          cnt_d   = WL_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACT: begin
        if (cnt_q == '0) begin
          state_d = we_q ? S_DONE : S_SENSE;
          cnt_d   = we_q ? '0 : SA_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SENSE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
          // No wordline was driven for an out-of-range row, so the sense
          // amps carry nothing meaningful; return zero instead.
          rdata_d = in_range ? sa_out : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All array-facing controls decode from registered state only.
  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign precharge_en = (state_q == S_IDLE) || (state_q == S_PRE);
  assign wl_sel       = (((state_q == S_ACT) || (state_q == S_SENSE)) && in_range)
                        ? (WL_ONE << addr_q) : '0;
  assign wd_en        = (state_q == S_ACT) && we_q && in_range;
  assign sa_en        = (state_q == S_SENSE);
  assign rsp_valid    = (state_q == S_DONE);
  assign rsp_rdata    = rdata_q;
  assign data_in      = data_in_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;
  localparam int ROWS = 16;
  localparam int COLS = 8;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req_valid = '0;
  logic [1:0]      req_we    = '0;
  logic [AW-1:0]   req_addr  [2] = '{5'd0, 5'd0};
  logic [COLS-1:0] req_wdata [2] = '{8'd0, 8'd0};
  logic [COLS-1:0] sa_out    [2] = '{8'd0, 8'd0};
  wire  [1:0]      req_ready, rsp_valid, precharge_en, wd_en, sa_en;
  wire  [COLS-1:0] rsp_rdata [2];
  wire  [COLS-1:0] data_in   [2];
  wire  [ROWS-1:0] wl_sel    [2];

  sram_access_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW),
                     .PRE_CYC(1), .WL_CYC(2), .SA_CYC(1)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .precharge_en(precharge_en[0]), .wl_sel(wl_sel[0]), .wd_en(wd_en[0]),
    .data_in(data_in[0]), .sa_en(sa_en[0]), .sa_out(sa_out[0])
  );

  sram_access_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW),
                     .PRE_CYC(2), .WL_CYC(3), .SA_CYC(2)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .precharge_en(precharge_en[1]), .wl_sel(wl_sel[1]), .wd_en(wd_en[1]),
    .data_in(data_in[1]), .sa_en(sa_en[1]), .sa_out(sa_out[1])
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h, expected %0h (t=%0t)", d, nm, act, exp, $time);
    end
  endtask

  // Timeline model: an access is described by its cycle index j since the
  // accepting edge; phase boundaries are sums of the configured cycle counts.
  int P [2] = '{1, 2};
  int W [2] = '{2, 3};
  int S [2] = '{1, 2};
  bit              m_busy  [2] = '{1'b0, 1'b0};
  int              m_j     [2] = '{0, 0};
  logic            m_we    [2] = '{1'b0, 1'b0};
  logic [AW-1:0]   m_addr  [2] = '{5'd0, 5'd0};
  logic [COLS-1:0] m_din   [2] = '{8'd0, 8'd0};
  logic [COLS-1:0] m_rdata [2] = '{8'd0, 8'd0};

  function automatic int lat_of(input int d);
    return P[d] + W[d] + (m_we[d] ? 0 : S[d]);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0; m_j[d] = 0; m_we[d] = 1'b0; m_addr[d] = '0;
        m_din[d] = '0; m_rdata[d] = '0;
      end else if (m_busy[d]) begin
        if (!m_we[d] && m_j[d] == lat_of(d) - 1)
          m_rdata[d] = (int'(m_addr[d]) < ROWS) ? sa_out[d] : '0;
        m_j[d]++;
        if (m_j[d] > lat_of(d)) m_busy[d] = 1'b0;
      end else if (req_valid[d]) begin
        m_busy[d] = 1'b1; m_j[d] = 0;
        m_we[d]   = req_we[d];
        m_addr[d] = req_addr[d];
        if (req_we[d]) m_din[d] = req_wdata[d];
      end
    end
  end

  always @(negedge clk) begin : compare
    int L, j;
    bit b, act, sen, inr;
    logic [ROWS-1:0] ewl;
    for (int d = 0; d < 2; d++) begin
      b   = m_busy[d];
      j   = m_j[d];
      L   = lat_of(d);
      act = b && j >= P[d] && j < P[d] + W[d];
      sen = b && !m_we[d] && j >= P[d] + W[d] && j < L;
      inr = int'(m_addr[d]) < ROWS;
      ewl = ((act || sen) && inr) ? (ROWS'(1) << m_addr[d]) : '0;
      chk(d, "req_ready",    32'(req_ready[d]),    32'(!b && !rst));
      chk(d, "precharge_en", 32'(precharge_en[d]), 32'(!b || j < P[d]));
      chk(d, "wl_sel",       32'(wl_sel[d]),       32'(ewl));
      chk(d, "wd_en",        32'(wd_en[d]),        32'(act && m_we[d] && inr));
      chk(d, "sa_en",        32'(sa_en[d]),        32'(sen));
      chk(d, "rsp_valid",    32'(rsp_valid[d]),    32'(b && j == L));
      chk(d, "rsp_rdata",    32'(rsp_rdata[d]),    32'(m_rdata[d]));
      chk(d, "data_in",      32'(data_in[d]),      32'(m_din[d]));
      chk(d, "inv_pc_wl",    32'(precharge_en[d] && (|wl_sel[d])), 32'd0);
      chk(d, "inv_wd_1hot",  32'(wd_en[d] && !$onehot(wl_sel[d])), 32'd0);
      chk(d, "inv_sa_wd",    32'(sa_en[d] && wd_en[d]),            32'd0);
      chk(d, "inv_wl_1hot0", 32'($onehot0(wl_sel[d])),             32'd1);
    end
  end

  // Issues one request on dut d and observes it up to the response cycle.
  task automatic do_req(input int d, input logic we, input logic [AW-1:0] addr,
                        input logic [COLS-1:0] wd, input logic [COLS-1:0] sa, input bit hold,
                        output int t0, output int lat, output int wdcnt, output int sacnt,
                        output logic [ROWS-1:0] wlor);
    bit   acc = 1'b0;
    logic r;
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd; sa_out[d] = sa;
    req_valid[d] = 1'b1;
    t0 = -1; lat = -1; wdcnt = 0; sacnt = 0; wlor = '0;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk); r = req_ready[d];
      @(posedge clk); if (r) acc = 1'b1;
    end
    #1;
    if (!hold) req_valid[d] = 1'b0;
    if (!acc) begin
      chk(d, "accept_timeout", 32'd0, 32'd1);
      return;
    end
    t0 = cyc;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      wlor  |= wl_sel[d];
      wdcnt += int'(wd_en[d]);
      sacnt += int'(sa_en[d]);
      if (rsp_valid[d]) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk(d, "rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stim
    int t0, t1, lat, wdc, sac, rsp_cnt;
    logic [ROWS-1:0] wlo;
    logic rwe;

    // Reset values
    repeat (2) @(negedge clk);
    chk(0, "rst_precharge", 32'(precharge_en[0]), 32'd1);
    chk(0, "rst_wl_sel",    32'(wl_sel[0]),       32'd0);
    chk(0, "rst_rsp_rdata", 32'(rsp_rdata[0]),    32'd0);
    chk(0, "rst_data_in",   32'(data_in[0]),      32'd0);
    chk(0, "rst_ready",     32'(req_ready[0]),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk(0, "post_rst_ready", 32'(req_ready[0]), 32'd1);

    // Reset in the middle of a write's wordline phase
    req_we[0] = 1'b1; req_addr[0] = 5'd3; req_wdata[0] = 8'h77; req_valid[0] = 1'b1;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    chk(0, "midact_wd_en",  32'(wd_en[0]),  32'd1);
    chk(0, "midact_wl_sel", 32'(wl_sel[0]), 32'h0008);
    #2 rst = 1'b1;
    #1;
    chk(0, "rst_async_wl_sel",    32'(wl_sel[0]),       32'd0);
    chk(0, "rst_async_wd_en",     32'(wd_en[0]),        32'd0);
    chk(0, "rst_async_precharge", 32'(precharge_en[0]), 32'd1);
    chk(0, "rst_async_ready",     32'(req_ready[0]),    32'd0);
    chk(0, "rst_async_data_in",   32'(data_in[0]),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rsp_cnt += int'(rsp_valid[0]);
    end
    chk(0, "rst_dropped_rsp", 32'(rsp_cnt),      32'd0);
    chk(0, "rst_release_rdy", 32'(req_ready[0]), 32'd1);

    // Write addr 5
    do_req(0, 1'b1, 5'd5, 8'hA5, 8'h00, 1'b0, t0, lat, wdc, sac, wlo);
    chk(0, "wr_latency", 32'(lat), 32'd3);
    chk(0, "wr_wd_cnt",  32'(wdc), 32'd2);
    chk(0, "wr_sa_cnt",  32'(sac), 32'd0);
    chk(0, "wr_wl",      32'(wlo), 32'h0020);
    chk(0, "wr_data_in", 32'(data_in[0]), 32'hA5);

    // Read addr 5
    do_req(0, 1'b0, 5'd5, 8'h00, 8'h3C, 1'b0, t0, lat, wdc, sac, wlo);
    chk(0, "rd_latency", 32'(lat), 32'd4);
    chk(0, "rd_sa_cnt",  32'(sac), 32'd1);
    chk(0, "rd_wd_cnt",  32'(wdc), 32'd0);
    chk(0, "rd_wl",      32'(wlo), 32'h0020);
    chk(0, "rd_rdata",   32'(rsp_rdata[0]), 32'h3C);
    chk(0, "rd_data_in_held", 32'(data_in[0]), 32'hA5);

    // A write leaves the previous read data in place
    do_req(0, 1'b1, 5'd2, 8'h11, 8'hEE, 1'b0, t0, lat, wdc, sac, wlo);
    chk(0, "wr_rdata_held", 32'(rsp_rdata[0]), 32'h3C);
    chk(0, "wr2_data_in",   32'(data_in[0]),   32'h11);

    // Back-to-back with req_valid held high
    do_req(0, 1'b1, 5'd7, 8'h5A, 8'h00, 1'b1, t0, lat, wdc, sac, wlo);
    do_req(0, 1'b0, 5'd7, 8'h00, 8'hC3, 1'b0, t1, lat, wdc, sac, wlo);
    chk(0, "b2b_accept_gap", 32'(t1 - t0), 32'd5);
    chk(0, "b2b_rd_latency", 32'(lat), 32'd4);
    chk(0, "b2b_rdata",      32'(rsp_rdata[0]), 32'hC3);

    // Out-of-range row
    do_req(0, 1'b0, 5'd16, 8'h00, 8'hFF, 1'b0, t0, lat, wdc, sac, wlo);
    chk(0, "oor_latency", 32'(lat), 32'd4);
    chk(0, "oor_wl",      32'(wlo), 32'd0);
    chk(0, "oor_rdata",   32'(rsp_rdata[0]), 32'd0);
    do_req(0, 1'b1, 5'd17, 8'h42, 8'h00, 1'b0, t0, lat, wdc, sac, wlo);
    chk(0, "oor_wr_latency", 32'(lat), 32'd3);
    chk(0, "oor_wr_wd_cnt",  32'(wdc), 32'd0);

    // Longer phase configuration
    do_req(1, 1'b1, 5'd9, 8'h81, 8'h00, 1'b0, t0, lat, wdc, sac, wlo);
    chk(1, "long_wr_latency", 32'(lat), 32'd5);
    chk(1, "long_wr_wd_cnt",  32'(wdc), 32'd3);
    chk(1, "long_wr_wl",      32'(wlo), 32'h0200);
    do_req(1, 1'b0, 5'd9, 8'h00, 8'h96, 1'b0, t0, lat, wdc, sac, wlo);
    chk(1, "long_rd_latency", 32'(lat), 32'd7);
    chk(1, "long_rd_sa_cnt",  32'(sac), 32'd2);
    chk(1, "long_rd_rdata",   32'(rsp_rdata[1]), 32'h96);

    for (int n = 0; n < 1000; n++) begin
      rwe = 1'($urandom_range(0, 1));
      do_req(1, rwe, AW'($urandom_range(0, 17)), 8'($urandom), 8'($urandom),
             1'b0, t0, lat, wdc, sac, wlo);
      chk(1, "rand_latency", 32'(lat), rwe ? 32'd5 : 32'd7);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
